axil_reg_slave: RTL

AXI4-Lite slave register bank that terminates the control-plane writes and reads issued by the testbench `WriteReg`/`ReadReg` tasks and by the PS in hardware. It exposes NUM_REGS 32-bit registers to the fabric:
- read/write control registers drive `reg_out`;
- read-only registers return live `status_in`.

It sits directly downstream of the AXI4-Lite master, one per peripheral, on the `axilite_clk` domain.

---
 rtl/axil_reg_pkg.sv | 26 ++
 rtl/axil_reg_slave.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/axil_reg_pkg.sv
// Shared constants, channel state type and byte-merge helper for the AXI4-Lite register slave.
package axil_reg_pkg;

   localparam int         REG_W       = 32;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } chan_state_e;

   function automatic logic [REG_W-1:0] apply_wstrb(
      input logic [REG_W-1:0]   old,
      input logic [REG_W-1:0]   data,
      input logic [REG_W/8-1:0] strb
   );
      logic [REG_W-1:0] merged;
      merged = old;
      for (int b = 0; b < REG_W/8; b++) begin
         if (strb[b]) merged[8*b +: 8] = data[8*b +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register bank: RW control registers on reg_out, RO registers read live status_in.
module axil_reg_slave
   import axil_reg_pkg::*;
#(
   parameter int                  NUM_REGS   = 16,
   parameter int                  ADDR_WIDTH = 12,
   parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
   input  logic                      axilite_clk,
   input  logic                      axilite_aresetn,
   input  logic [ADDR_WIDTH-1:0]     s_axil_awaddr,
   input  logic [2:0]                s_axil_awprot,
   input  logic                      s_axil_awvalid,
   output logic                      s_axil_awready,
   input  logic [31:0]               s_axil_wdata,
   input  logic [3:0]                s_axil_wstrb,
   input  logic                      s_axil_wvalid,
   output logic                      s_axil_wready,
   output logic [1:0]                s_axil_bresp,
   output logic                      s_axil_bvalid,
   input  logic                      s_axil_bready,
   input  logic [ADDR_WIDTH-1:0]     s_axil_araddr,
   input  logic [2:0]                s_axil_arprot,
   input  logic                      s_axil_arvalid,
   output logic                      s_axil_arready,
   output logic [31:0]               s_axil_rdata,
   output logic [1:0]                s_axil_rresp,
   output logic                      s_axil_rvalid,
   input  logic                      s_axil_rready,
   output logic [NUM_REGS*32-1:0]    reg_out,
   input  logic [NUM_REGS*32-1:0]    status_in,
   output logic [NUM_REGS-1:0]       wr_pulse
);

   localparam int IDX_W = ADDR_WIDTH - 2;

   chan_state_e           wr_state_q, wr_state_d, rd_state_q, rd_state_d;
   logic                  en_q;
   logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
   logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
   logic [REG_W-1:0]      wdata_q, wdata_d;
   logic [3:0]            wstrb_q, wstrb_d;
   logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
   logic [REG_W-1:0]      rdata_q, rdata_d;
   logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
   logic [REG_W-1:0]      regs_q [NUM_REGS];
   logic [REG_W-1:0]      regs_d [NUM_REGS];

   logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
   logic [IDX_W-1:0]      wr_idx, rd_idx;
   logic [REG_W-1:0]      wr_data;
   logic [3:0]            wr_strb;
   logic                  unused_inputs;

   // en_q keeps every ready low while reset is asserted
   assign s_axil_awready = en_q && !aw_held_q && (wr_state_q == ST_IDLE);
   assign s_axil_wready  = en_q && !w_held_q && (wr_state_q == ST_IDLE);
   assign s_axil_arready = en_q && (rd_state_q == ST_IDLE);
   assign s_axil_bvalid  = (wr_state_q == ST_RESP);
   assign s_axil_rvalid  = (rd_state_q == ST_RESP);
   assign s_axil_bresp   = bresp_q;
   assign s_axil_rresp   = rresp_q;
   assign s_axil_rdata   = rdata_q;
   assign wr_pulse       = wr_pulse_q;

   assign aw_hs = s_axil_awvalid && s_axil_awready;
   assign w_hs  = s_axil_wvalid && s_axil_wready;
   assign b_hs  = s_axil_bvalid && s_axil_bready;
   assign ar_hs = s_axil_arvalid && s_axil_arready;
   assign r_hs  = s_axil_rvalid && s_axil_rready;

   // Commit looks through to a same-cycle handshake so bvalid follows the later handshake by one cycle
   assign wr_idx  = aw_hs ? s_axil_awaddr[ADDR_WIDTH-1:2] : aw_idx_q;
   assign wr_data = w_hs ? s_axil_wdata : wdata_q;
   assign wr_strb = w_hs ? s_axil_wstrb : wstrb_q;
   assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs) && (wr_state_q == ST_IDLE);
   assign rd_idx  = s_axil_araddr[ADDR_WIDTH-1:2];

   assign unused_inputs = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[1:0], s_axil_araddr[1:0]};

   always_comb begin
      aw_held_d  = aw_held_q;
      w_held_d   = w_held_q;
      aw_idx_d   = aw_idx_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      wr_state_d = wr_state_q;
      bresp_d    = bresp_q;
      wr_pulse_d = '0;
      regs_d     = regs_q;
      if (aw_hs) begin
         aw_held_d = 1'b1;
         aw_idx_d  = s_axil_awaddr[ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
         w_held_d = 1'b1;
         wdata_d  = s_axil_wdata;
         wstrb_d  = s_axil_wstrb;
      end
      if (b_hs) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
      end
      if (commit) begin
         wr_state_d = ST_RESP;
         bresp_d    = RESP_SLVERR;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_idx == IDX_W'(i) && !RO_MASK[i]) begin
               regs_d[i]     = apply_wstrb(regs_q[i], wr_data, wr_strb);
               wr_pulse_d[i] = 1'b1;
               bresp_d       = RESP_OKAY;
            end
         end
      end else if (b_hs) begin
         wr_state_d = ST_IDLE;
      end
   end

   always_comb begin
      rd_state_d = rd_state_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      if (ar_hs) begin
         rd_state_d = ST_RESP;
         rdata_d    = '0;
         rresp_d    = RESP_SLVERR;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
               rresp_d = RESP_OKAY;
               rdata_d = RO_MASK[i] ? status_in[REG_W*i +: REG_W] : regs_q[i];
            end
         end
      end else if (r_hs) begin
         rd_state_d = ST_IDLE;
      end
   end

   always_comb begin
      reg_out = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (!RO_MASK[i]) reg_out[REG_W*i +: REG_W] = regs_q[i];
      end
   end

   always_ff @(posedge axilite_clk or negedge axilite_aresetn) begin
      if (!axilite_aresetn) begin
         en_q       <= 1'b0;
         wr_state_q <= ST_IDLE;
         rd_state_q <= ST_IDLE;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         aw_idx_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bresp_q    <= '0;
         rresp_q    <= '0;
         rdata_q    <= '0;
         wr_pulse_q <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         en_q       <= 1'b1;
         wr_state_q <= wr_state_d;
         rd_state_q <= rd_state_d;
         aw_held_q  <= aw_held_d;
         w_held_q   <= w_held_d;
         aw_idx_q   <= aw_idx_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         bresp_q    <= bresp_d;
         rresp_q    <= rresp_d;
         rdata_q    <= rdata_d;
         wr_pulse_q <= wr_pulse_d;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      end
   end

endmodule
